// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receiver.
//   uart_state_t : receiver FSM state encoding
//   DATA_BITS    : payload bits per frame
//   calc_div     : clocks per oversample tick, rounded to nearest
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int DATA_BITS = 8;

  // round(clk_hz / (baud * oversample)) using integer arithmetic
  function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
    int per_tick;
    per_tick = baud * oversample;
    return (clk_hz + per_tick / 2) / per_tick;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator.
//   clk     : system clock
//   reset   : synchronous active-high reset
//   restart : realigns the tick phase; the first tick follows DIV clocks later
//   tick    : one-clock pulse every DIV clocks
module uart_baud_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_receptor.sv
// uart_receptor: oversampling UART receiver, 8 data bits LSB first, 1 stop bit.
// Optional even parity bit is compiled in with macro UART_PARITY_EN.
//   clk         : system clock, rising edge
//   reset       : synchronous active-high reset
//   rx          : asynchronous serial input, idle high
//   rxData      : last correctly received byte
//   rxReady     : one-cycle pulse, rxData newly valid
//   frameError  : one-cycle pulse, stop bit sampled low
//   parityError : one-cycle pulse, parity mismatch (constant 0 without UART_PARITY_EN)
module uart_receptor
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int BAUD        = 115_200,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rxData,
  output logic       rxReady,
  output logic       frameError,
  output logic       parityError
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  if (DIV < 2) begin : g_div_chk
    $error("uart_receptor: clock too slow for BAUD*OVERSAMPLE (DIV < 2)");
  end
  if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_os_chk
    $error("uart_receptor: OVERSAMPLE must be an even integer >= 8");
  end

  uart_state_t          state, state_nx;
  logic                 rx_meta, rx_s, rx_prev;
  logic                 fall, restart, tick, sample;
  logic [TW-1:0]        tick_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err;
  logic                 ready_nx, fe_nx;

  // Synchronizer stage; rx_prev feeds the start-edge detector
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall    = rx_prev & ~rx_s;
  assign restart = (state == IDLE) && fall;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    sample   = 1'b0;
    ready_nx = 1'b0;
    fe_nx    = 1'b0;
    case (state)
      IDLE:  if (fall) state_nx = START;
      START: begin
        sample = tick && (tick_cnt == HALF_LAST);
        // a start bit that is high again at mid-bit was a glitch
        if (sample) state_nx = rx_s ? IDLE : DATA;
      end
      DATA: begin
        sample = tick && (tick_cnt == FULL_LAST);
        if (sample && (bit_cnt == LAST_BIT)) begin
`ifdef UART_PARITY_EN
          state_nx = PARITY;
`else
          state_nx = STOP;
`endif
        end
      end
      PARITY: begin
        sample = tick && (tick_cnt == FULL_LAST);
        if (sample) state_nx = STOP;
      end
      STOP: begin
        sample = tick && (tick_cnt == FULL_LAST);
        if (sample) begin
          state_nx = IDLE;
          ready_nx = rx_s && !par_err;
          fe_nx    = !rx_s;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Bit timing, shift register and registered result pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      rxData     <= '0;
      rxReady    <= 1'b0;
      frameError <= 1'b0;
    end else begin
      rxReady    <= ready_nx;
      frameError <= fe_nx;
      if (ready_nx) rxData <= shreg;

      if (state == IDLE) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        if (sample)    tick_cnt <= '0;
        else if (tick) tick_cnt <= tick_cnt + TW'(1);
        if ((state == DATA) && sample) begin
          shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_err     <= 1'b0;
      parityError <= 1'b0;
    end else begin
      parityError <= (state == STOP) && sample && rx_s && par_err;
      if (state == START) begin
        par_err <= 1'b0;
      end else if ((state == PARITY) && sample) begin
        // even parity: the parity bit equals the XOR of the data bits
        par_err <= (rx_s != (^shreg));
      end
    end
  end
`else
  assign par_err     = 1'b0;
  assign parityError = 1'b0;
`endif

endmodule

// File: doc/uart_receptor.md
UART_RECEPTOR -- requirements
Module: uart_receptor

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 25_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115_200, serial bit rate.
REQ-003 Parameter OVERSAMPLE, default 16, sample ticks per bit; SHALL be an even integer >= 8.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rx  input  1  asynchronous serial line, idle high.
REQ-007 rxData  output  8  last correctly received byte.
REQ-008 rxReady  output  1  one-cycle pulse; rxData is newly valid.
REQ-009 frameError  output  1  one-cycle pulse; stop bit sampled low.
REQ-010 parityError  output  1  one-cycle pulse; parity mismatch. Tied 0 when parity is compiled out.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-012 Tick generator SHALL pulse once every DIV clocks, with DIV = round(CLK_FREQ_HZ / (BAUD*OVERSAMPLE)). Elaboration SHALL fail if DIV < 2.
REQ-013 States: IDLE, START, DATA, PARITY, STOP. Frame format: 1 start bit, 8 data bits LSB first, optional parity, 1 stop bit.
REQ-014 IDLE -> START on a high-to-low transition of the synchronized rx. The tick counter SHALL restart at that transition.
REQ-015 START: after OVERSAMPLE/2 ticks, resample rx. If low, go to DATA. If high (glitch), return to IDLE with no output pulse.
REQ-016 DATA: sample every OVERSAMPLE ticks, at mid-bit, into a shift register. A 3-bit counter tracks bits. After bit 7, go to PARITY (macro defined) or STOP.
REQ-017 PARITY: sample at mid-bit, compare with the even parity of the 8 data bits, record any mismatch, then go to STOP.
REQ-018 STOP: sample at mid-bit.
 - Stop bit high, no parity mismatch: load rxData, pulse rxReady.
 - Stop bit low: pulse frameError only.
 - Stop bit high, parity mismatch: pulse parityError only.
 - In all cases, return to IDLE.
REQ-019 Latency: the pulse and any rxData update SHALL appear exactly 1 clock after the mid-stop sampling tick.
REQ-020 rxData SHALL change only together with rxReady; on any error it holds its previous value.
REQ-021 Back-to-back frames: a start edge detected immediately after STOP SHALL be accepted with no idle bits in between.
REQ-022 At most one of rxReady, frameError and parityError SHALL be high in any cycle.

Reset
REQ-023 With reset high, on the next clk edge:
 - state = IDLE
 - rxData = 0x00
 - all pulses = 0
 - tick, bit and shift counters = 0
 - synchronizer flops = 1
REQ-024 Reset asserted mid-frame SHALL abandon the frame without any pulse. The next full frame after reset deasserts SHALL be received correctly.

Configuration
REQ-025 Macro UART_PARITY_EN:
 - Defined: the PARITY state and the even-parity check are compiled in; frames are 11 bits.
 - Undefined: PARITY is never entered, parityError is constant 0, and frames are 10 bits.

Structure
REQ-026 Package uart_pkg SHALL hold the state enum type, DATA_BITS = 8, and the DIV computation function.
REQ-027 Sub-module uart_baud_tick SHALL produce the oversample tick and accept a restart input.

Verification
Bench parameters for all scenarios: CLK_FREQ_HZ = 1_600_000, BAUD = 50_000, OVERSAMPLE = 16. This gives DIV = 2, 32 clocks per bit.
REQ-028 Frame 0xB5 with a good stop bit -> one rxReady pulse, rxData = 0xB5, no error pulses.
REQ-029 rx low for 4 ticks, then high -> no pulse of any kind, FSM back in IDLE, rxData unchanged.
REQ-030 Data 0x3C with stop bit = 0 after a prior 0xB5 -> one frameError pulse, no rxReady, rxData stays 0xB5.
REQ-031 Frames 0x00 then 0xFF back-to-back with no idle gap -> two rxReady pulses 320 clocks apart, values 0x00 then 0xFF.
REQ-032 reset pulsed during data bit 4 -> rxData = 0x00, no pulse. A following frame 0x81 -> rxReady with rxData = 0x81.
REQ-033 (UART_PARITY_EN) Data 0x07 with parity bit 0 -> one parityError pulse, no rxReady. The same data with parity bit 1 -> rxReady, rxData = 0x07.
